// File: rtl/pixel_pkg.sv
// Shared pixel-pipeline definitions: default channel width, fade FSM encoding
// and the saturating channel arithmetic used by the dimmer and the brightness shader.
package pixel_pkg;

    localparam int PIX_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } fade_state_t;

    // Borrow out of the extended subtract means the channel would go negative.
    function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [PIX_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[PIX_W] ? '0 : diff[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [PIX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PIX_W] ? '1 : sum[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/dim_fade_ctrl.sv
// Fade engine: walks dim_level toward a latched target by FADE_STEP once every
// FRAMES_PER_STEP accepted start-of-frame beats, clamping exactly at the target.
module dim_fade_ctrl
    import pixel_pkg::*;
#(
    parameter int DATA_W          = PIX_W,
    parameter int FADE_STEP       = 1,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fade_start,
    input  logic [DATA_W-1:0] dim_target,
    input  logic              sof_accept,
    output logic [DATA_W-1:0] dim_level,
    output fade_state_t       state
);

    localparam int CNT_W = 4;
    localparam logic [DATA_W-1:0] STEP     = DATA_W'(FADE_STEP);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    fade_state_t       state_nxt;
    logic [CNT_W-1:0]  frame_cnt, frame_cnt_nxt;
    logic [DATA_W-1:0] target, target_nxt;
    logic [DATA_W-1:0] level_nxt;
    logic [DATA_W-1:0] gap;
    logic [DATA_W-1:0] stepped;

    // Next level one step toward target; a gap no larger than STEP lands exactly on it.
    always_comb begin
        gap     = '0;
        stepped = dim_level;
        if (target >= dim_level) begin
            gap     = target - dim_level;
            stepped = (gap <= STEP) ? target : dim_level + STEP;
        end else begin
            gap     = dim_level - target;
            stepped = (gap <= STEP) ? target : dim_level - STEP;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        target_nxt    = target;
        level_nxt     = dim_level;
        case (state)
            ST_IDLE: begin
                if (fade_start) begin
                    target_nxt    = dim_target;
                    frame_cnt_nxt = '0;
                    if (dim_target != dim_level) begin
                        state_nxt = ST_FADE;
                    end
                end
            end
            ST_FADE: begin
                // A retarget restarts frame pacing and suppresses any step this cycle.
                if (fade_start) begin
                    target_nxt    = dim_target;
                    frame_cnt_nxt = '0;
                    if (dim_target == dim_level) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (sof_accept) begin
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt_nxt = '0;
                        level_nxt     = stepped;
                        if (stepped == target) begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            target    <= '0;
            dim_level <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
            target    <= target_nxt;
            dim_level <= level_nxt;
        end
    end

endmodule

// File: rtl/pixel_dimmer_4bit.sv
// Streaming pixel dimmer: subtracts dim_level from each channel (floored at 0)
// behind a single valid/ready output register, with a frame-paced fade engine.
module pixel_dimmer_4bit
    import pixel_pkg::*;
#(
    parameter int DATA_W          = PIX_W,
    parameter int FADE_STEP       = 1,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_red,
    input  logic [DATA_W-1:0] s_green,
    input  logic [DATA_W-1:0] s_blue,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_red,
    output logic [DATA_W-1:0] m_green,
    output logic [DATA_W-1:0] m_blue,
    output logic              m_sof,
    input  logic              fade_start,
    input  logic [DATA_W-1:0] dim_target,
    output logic [DATA_W-1:0] dim_level,
    output logic              fading
);

    // Handshake: a beat transfers on any clk edge where valid && ready; a source
    // holds valid and data stable until it transfers, and ready may depend on
    // downstream ready but never on valid.
    logic              accept;
    logic [DATA_W-1:0] red_d, green_d, blue_d;
    fade_state_t       fade_state;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign fading  = (fade_state == ST_FADE);

    generate
        if (DATA_W == PIX_W) begin : g_pkg_sub
            assign red_d   = sat_sub(s_red, dim_level);
            assign green_d = sat_sub(s_green, dim_level);
            assign blue_d  = sat_sub(s_blue, dim_level);
        end else begin : g_wide_sub
            function automatic logic [DATA_W-1:0] sub_w(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b);
                logic [DATA_W:0] diff;
                diff = {1'b0, a} - {1'b0, b};
                return diff[DATA_W] ? '0 : diff[DATA_W-1:0];
            endfunction
            assign red_d   = sub_w(s_red, dim_level);
            assign green_d = sub_w(s_green, dim_level);
            assign blue_d  = sub_w(s_blue, dim_level);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_red   <= '0;
            m_green <= '0;
            m_blue  <= '0;
            m_sof   <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_red   <= red_d;
            m_green <= green_d;
            m_blue  <= blue_d;
            m_sof   <= s_sof;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    dim_fade_ctrl #(
        .DATA_W          (DATA_W),
        .FADE_STEP       (FADE_STEP),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_fade (
        .clk        (clk),
        .rst        (rst),
        .fade_start (fade_start),
        .dim_target (dim_target),
        .sof_accept (accept && s_sof),
        .dim_level  (dim_level),
        .state      (fade_state)
    );

endmodule

// File: tb/tb_pixel_dimmer_4bit.sv
// Bench for pixel_dimmer_4bit: scoreboarded pixel stream on a step-1 instance,
// fade/retarget pacing on a step-4 instance.
module tb_pixel_dimmer_4bit;

    logic       clk;
    logic       rst;
    logic       s_valid, s_ready, s_sof;
    logic [3:0] s_red, s_green, s_blue;
    logic       m_valid, m_ready, m_sof;
    logic [3:0] m_red, m_green, m_blue;
    logic       fade_start, fading;
    logic [3:0] dim_target, dim_level;

    logic       b_s_valid, b_s_ready, b_s_sof;
    logic [3:0] b_s_red, b_s_green, b_s_blue;
    logic       b_m_valid, b_m_ready, b_m_sof;
    logic [3:0] b_m_red, b_m_green, b_m_blue;
    logic       b_fade_start, b_fading;
    logic [3:0] b_dim_target, b_dim_level;

    int total = 0;
    int bad   = 0;
    logic [3:0]  model_level = 4'd0;
    logic [12:0] exp_q[$];
    logic [12:0] exp_beat;

    pixel_dimmer_4bit #(.DATA_W(4), .FADE_STEP(1), .FRAMES_PER_STEP(2)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_red(s_red), .s_green(s_green), .s_blue(s_blue), .s_sof(s_sof),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_red(m_red), .m_green(m_green), .m_blue(m_blue), .m_sof(m_sof),
        .fade_start(fade_start), .dim_target(dim_target),
        .dim_level(dim_level), .fading(fading)
    );

    pixel_dimmer_4bit #(.DATA_W(4), .FADE_STEP(4), .FRAMES_PER_STEP(2)) dut4 (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_red(b_s_red), .s_green(b_s_green), .s_blue(b_s_blue), .s_sof(b_s_sof),
        .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_red(b_m_red), .m_green(b_m_green), .m_blue(b_m_blue), .m_sof(b_m_sof),
        .fade_start(b_fade_start), .dim_target(b_dim_target),
        .dim_level(b_dim_level), .fading(b_fading)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] dimmed(input logic [3:0] a, input logic [3:0] lvl);
        return (a >= lvl) ? 4'(a - lvl) : 4'd0;
    endfunction

    // scoreboard: every transferred output beat must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_beat: unexpected beat got=%h", {m_sof, m_red, m_green, m_blue});
            end else begin
                exp_beat = exp_q.pop_front();
                if ({m_sof, m_red, m_green, m_blue} !== exp_beat) begin
                    bad++;
                    $display("FAIL out_beat: got=%h expected=%h",
                             {m_sof, m_red, m_green, m_blue}, exp_beat);
                end
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [3:0] r, input logic [3:0] g,
                             input logic [3:0] b, input logic sof);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_red   = r;
        s_green = g;
        s_blue  = b;
        s_sof   = sof;
        #1;
        while (s_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_beat: s_ready got=%b expected=1 within 20 cycles", s_ready);
            s_valid = 1'b0;
        end else begin
            exp_q.push_back({sof, dimmed(r, model_level), dimmed(g, model_level),
                             dimmed(b, model_level)});
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_sof   = 1'b0;
        end
    endtask

    task automatic pulse_fade(input logic [3:0] t);
        fade_start = 1'b1;
        dim_target = t;
        @(posedge clk);
        #1;
        fade_start = 1'b0;
    endtask

    task automatic b_pulse_fade(input logic [3:0] t);
        b_fade_start = 1'b1;
        b_dim_target = t;
        @(posedge clk);
        #1;
        b_fade_start = 1'b0;
    endtask

    task automatic b_sof_beat();
        b_s_valid = 1'b1;
        b_s_sof   = 1'b1;
        @(posedge clk);
        #1;
        b_s_valid = 1'b0;
        b_s_sof   = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total++;
        if ({m_valid, m_sof, m_red, m_green, m_blue} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs: got=%h expected=0", {m_valid, m_sof, m_red, m_green, m_blue});
        end
        total++;
        if (dim_level !== 4'd0 || fading !== 1'b0) begin
            bad++;
            $display("FAIL reset_fade: level=%0d fading=%b expected level=0 fading=0", dim_level, fading);
        end
        rst = 1'b0;
        #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got=%b expected=1", s_ready);
        end
    endtask

    task automatic test_basic();
        send_beat(4'd5, 4'd6, 4'd3, 1'b0);
        total++;
        if (m_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency: m_valid got=%b expected=1", m_valid);
        end
        idle(1);
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: m_valid got=%b expected=0", m_valid);
        end
        for (int i = 0; i < 4; i++) begin
            send_beat(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'b0);
        end
        idle(1);
    endtask

    task automatic test_fade_pacing();
        pulse_fade(4'd3);
        total++;
        if (fading !== 1'b1 || dim_level !== 4'd0) begin
            bad++;
            $display("FAIL fade_start: fading=%b level=%0d expected fading=1 level=0", fading, dim_level);
        end
        send_beat(4'd7, 4'd1, 4'd0, 1'b1);
        total++;
        if (dim_level !== 4'd0) begin
            bad++;
            $display("FAIL fade_sof1: level got=%0d expected=0", dim_level);
        end
        send_beat(4'd7, 4'd1, 4'd0, 1'b1);
        model_level = 4'd1;
        total++;
        if (dim_level !== 4'd1 || fading !== 1'b1) begin
            bad++;
            $display("FAIL fade_sof2: level=%0d fading=%b expected level=1 fading=1", dim_level, fading);
        end
        // stall an sof beat behind a held output for three cycles
        idle(1);
        m_ready = 1'b0;
        send_beat(4'd9, 4'd9, 4'd9, 1'b0);
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_red   = 4'd10;
        s_green = 4'd1;
        s_blue  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (s_ready !== 1'b0 || dim_level !== 4'd1) begin
                bad++;
                $display("FAIL fade_stall: s_ready=%b level=%0d expected s_ready=0 level=1", s_ready, dim_level);
            end
        end
        m_ready = 1'b1;
        #1;
        exp_q.push_back({1'b1, dimmed(4'd10, model_level), dimmed(4'd1, model_level),
                         dimmed(4'd0, model_level)});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        total++;
        if (dim_level !== 4'd1) begin
            bad++;
            $display("FAIL fade_sof3: level got=%0d expected=1", dim_level);
        end
        send_beat(4'd3, 4'd2, 4'd1, 1'b1);
        model_level = 4'd2;
        total++;
        if (dim_level !== 4'd2) begin
            bad++;
            $display("FAIL fade_sof4: level got=%0d expected=2", dim_level);
        end
        send_beat(4'd3, 4'd2, 4'd1, 1'b1);
        send_beat(4'd3, 4'd2, 4'd1, 1'b1);
        model_level = 4'd3;
        total++;
        if (dim_level !== 4'd3 || fading !== 1'b0) begin
            bad++;
            $display("FAIL fade_sof6: level=%0d fading=%b expected level=3 fading=0", dim_level, fading);
        end
        send_beat(4'd3, 4'd2, 4'd1, 1'b1);
        send_beat(4'd3, 4'd2, 4'd1, 1'b1);
        total++;
        if (dim_level !== 4'd3) begin
            bad++;
            $display("FAIL fade_idle_hold: level got=%0d expected=3", dim_level);
        end
        idle(1);
    endtask

    task automatic test_floor();
        pulse_fade(4'd4);
        send_beat(4'd0, 4'd0, 4'd0, 1'b1);
        send_beat(4'd0, 4'd0, 4'd0, 1'b1);
        model_level = 4'd4;
        total++;
        if (dim_level !== 4'd4 || fading !== 1'b0) begin
            bad++;
            $display("FAIL floor_fade: level=%0d fading=%b expected level=4 fading=0", dim_level, fading);
        end
        send_beat(4'd2, 4'd13, 4'd4, 1'b0);
        send_beat(4'd15, 4'd15, 4'd15, 1'b0);
        send_beat(4'd4, 4'd3, 4'd0, 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        send_beat(4'd9, 4'd8, 4'd7, 1'b0);
        s_valid = 1'b1;
        s_sof   = 1'b0;
        s_red   = 4'd3;
        s_green = 4'd12;
        s_blue  = 4'd15;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || {m_red, m_green, m_blue} !== 12'h543) begin
                bad++;
                $display("FAIL bp_hold: s_ready=%b m_valid=%b rgb=%h expected s_ready=0 m_valid=1 rgb=543",
                         s_ready, m_valid, {m_red, m_green, m_blue});
            end
        end
        m_ready = 1'b1;
        #1;
        exp_q.push_back({1'b0, dimmed(4'd3, model_level), dimmed(4'd12, model_level),
                         dimmed(4'd15, model_level)});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_order: pending got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_retarget();
        b_pulse_fade(4'd6);
        b_sof_beat();
        total++;
        if (b_dim_level !== 4'd0 || b_fading !== 1'b1) begin
            bad++;
            $display("FAIL rt_sof1: level=%0d fading=%b expected level=0 fading=1", b_dim_level, b_fading);
        end
        b_sof_beat();
        total++;
        if (b_dim_level !== 4'd4) begin
            bad++;
            $display("FAIL rt_step4: level got=%0d expected=4", b_dim_level);
        end
        b_sof_beat();
        b_sof_beat();
        total++;
        if (b_dim_level !== 4'd6 || b_fading !== 1'b0) begin
            bad++;
            $display("FAIL rt_clamp6: level=%0d fading=%b expected level=6 fading=0", b_dim_level, b_fading);
        end
        b_s_red   = 4'd7;
        b_s_green = 4'd9;
        b_s_blue  = 4'd3;
        b_sof_beat();
        total++;
        if (b_m_valid !== 1'b1 || {b_m_red, b_m_green, b_m_blue} !== 12'h130) begin
            bad++;
            $display("FAIL rt_pixel: valid=%b rgb=%h expected valid=1 rgb=130",
                     b_m_valid, {b_m_red, b_m_green, b_m_blue});
        end
        b_pulse_fade(4'd1);
        b_sof_beat();
        b_sof_beat();
        total++;
        if (b_dim_level !== 4'd2 || b_fading !== 1'b1) begin
            bad++;
            $display("FAIL rt_down2: level=%0d fading=%b expected level=2 fading=1", b_dim_level, b_fading);
        end
        b_sof_beat();
        // retarget lands on an sof accept that would otherwise step
        b_fade_start = 1'b1;
        b_dim_target = 4'd1;
        b_sof_beat();
        b_fade_start = 1'b0;
        total++;
        if (b_dim_level !== 4'd2 || b_fading !== 1'b1) begin
            bad++;
            $display("FAIL rt_coincident: level=%0d fading=%b expected level=2 fading=1", b_dim_level, b_fading);
        end
        b_sof_beat();
        b_sof_beat();
        total++;
        if (b_dim_level !== 4'd1 || b_fading !== 1'b0) begin
            bad++;
            $display("FAIL rt_down1: level=%0d fading=%b expected level=1 fading=0", b_dim_level, b_fading);
        end
        b_pulse_fade(4'd5);
        b_pulse_fade(4'd1);
        total++;
        if (b_dim_level !== 4'd1 || b_fading !== 1'b0) begin
            bad++;
            $display("FAIL rt_same_target: level=%0d fading=%b expected level=1 fading=0", b_dim_level, b_fading);
        end
    endtask

    task automatic test_reset_mid();
        pulse_fade(4'd0);
        send_beat(4'd8, 4'd8, 4'd8, 1'b1);
        idle(1);
        m_ready = 1'b0;
        send_beat(4'd15, 4'd6, 4'd2, 1'b0);
        idle(1);
        total++;
        if (m_valid !== 1'b1 || fading !== 1'b1 || dim_level !== 4'd4) begin
            bad++;
            $display("FAIL mid_setup: m_valid=%b fading=%b level=%0d expected 1 1 4", m_valid, fading, dim_level);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_level = 4'd0;
        #1;
        total++;
        if (m_valid !== 1'b0 || dim_level !== 4'd0 || fading !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: m_valid=%b level=%0d fading=%b s_ready=%b expected 0 0 0 1",
                     m_valid, dim_level, fading, s_ready);
        end
        m_ready = 1'b1;
        send_beat(4'd5, 4'd6, 4'd3, 1'b0);
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_sof = 1'b0; s_red = '0; s_green = '0; s_blue = '0;
        m_ready = 1'b1; fade_start = 1'b0; dim_target = '0;
        b_s_valid = 1'b0; b_s_sof = 1'b0; b_s_red = '0; b_s_green = '0; b_s_blue = '0;
        b_m_ready = 1'b1; b_fade_start = 1'b0; b_dim_target = '0;

        test_reset();
        test_basic();
        test_fade_pacing();
        test_floor();
        test_back_to_back();
        test_retarget();
        test_reset_mid();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: pending got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
